stream_word_packer: RTL and testbench



---
 rtl/stream_word_packer_pkg.sv | 16 +
 rtl/stream_word_packer_out_reg.sv | 35 +++
 rtl/stream_word_packer.sv | 99 +++++++++
 tb/tb_stream_word_packer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_word_packer_pkg.sv
// Shared word layout and state encoding for the 72-bit FIFO word packer/unpacker pair.
package stream_word_packer_pkg;

  localparam int unsigned DATA_LO  = 0;
  localparam int unsigned DATA_HI  = 32;
  localparam int unsigned LAST_BIT = 64;
  localparam int unsigned HALF_BIT = 65;
  localparam int unsigned SEQ_LSB  = 66;
  localparam int unsigned SEQ_W    = 6;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_e;

endpackage

// File: rtl/stream_word_packer_out_reg.sv
// Single-entry output register: holds the packed word until the FIFO accepts it.
module stream_out_reg #(
  parameter int unsigned W = 72
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         out_free_c
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // A load wins over an accept, so a same-cycle accept+load keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= load_data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign out_free_c = ~valid_q | ready_i;

endmodule

// File: rtl/stream_word_packer.sv
// Packs pairs of input beats into one FIFO word {seq, half, last, hi, lo}; odd tails go out half-filled.
module stream_word_packer
  import stream_word_packer_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 72,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [IN_WIDTH-1:0]  ss_data,
  input  logic                 ss_last,
  input  logic                 ss_valid,
  output logic                 ss_ready,
  output logic [OUT_WIDTH-1:0] ms_data,
  output logic                 ms_valid,
  input  logic                 ms_ready,
  output logic [CNT_WIDTH-1:0] pkt_count
);

  state_e                 state_q, state_d;
  logic [IN_WIDTH-1:0]    low_q, low_d;
  logic [SEQ_W-1:0]       seq_q, seq_d;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   load_c;
  logic [OUT_WIDTH-1:0]   load_data_c;
  logic                   out_free_c;
  logic                   in_xfer_c;

  // A low beat can always be parked; only completing a word needs the output slot.
  assign ss_ready  = resetn & (out_free_c | ((state_q == EMPTY) & ~ss_last));
  assign in_xfer_c = ss_valid & ss_ready;

  always_comb begin
    state_d     = state_q;
    low_d       = low_q;
    seq_d       = seq_q;
    load_c      = 1'b0;
    load_data_c = '0;
    if (in_xfer_c) begin
      unique case (state_q)
        EMPTY: begin
          if (ss_last) begin
            load_c      = 1'b1;
            load_data_c = OUT_WIDTH'({seq_q, 1'b1, 1'b1, IN_WIDTH'(0), ss_data});
            seq_d       = '0;
          end else begin
            low_d   = ss_data;
            state_d = HALF;
          end
        end
        HALF: begin
          load_c      = 1'b1;
          load_data_c = OUT_WIDTH'({seq_q, 1'b0, ss_last, ss_data, low_q});
          seq_d       = ss_last ? '0 : seq_q + SEQ_W'(1);
          state_d     = EMPTY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= EMPTY;
      low_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
      seq_q   <= seq_d;
    end
  end

  // Packets count when their last word leaves, not when it is built.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (ms_valid & ms_ready & ms_data[LAST_BIT]) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign pkt_count = cnt_q;

  stream_out_reg #(
    .W (OUT_WIDTH)
  ) u_out_reg (
    .clk         (clk),
    .rst_n       (resetn),
    .load_i      (load_c),
    .load_data_i (load_data_c),
    .ready_i     (ms_ready),
    .valid_o     (ms_valid),
    .data_o      (ms_data),
    .out_free_c  (out_free_c)
  );

endmodule

// File: tb/tb_stream_word_packer.sv
// Directed bench for stream_word_packer: pairing, odd tails, backpressure, seq wrap and async reset.
module tb_stream_word_packer;
  import stream_word_packer_pkg::*;

  logic        clk;
  logic        resetn;
  logic [31:0] ss_data;
  logic        ss_last;
  logic        ss_valid;
  logic        ss_ready;
  logic [71:0] ms_data;
  logic        ms_valid;
  logic        ms_ready;
  logic [15:0] pkt_count;

  int errors = 0;
  int checks = 0;
  int stalls;
  bit stuck;
  logic [71:0] got[$];

  stream_word_packer dut (
    .clk       (clk),
    .resetn    (resetn),
    .ss_data   (ss_data),
    .ss_last   (ss_last),
    .ss_valid  (ss_valid),
    .ss_ready  (ss_ready),
    .ms_data   (ms_data),
    .ms_valid  (ms_valid),
    .ms_ready  (ms_ready),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs only change 1ns after posedge, so a negedge sample sees the coming handshake.
  always @(negedge clk) begin
    if (resetn && ms_valid && ms_ready) got.push_back(ms_data);
  end

  // Offers n consecutive beats base+i, last on the final one; called at posedge+1.
  task automatic send_pkt(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      ss_data  = base + 32'(i);
      ss_last  = (i == n - 1);
      ss_valid = 1'b1;
      forever begin
        @(negedge clk);
        if (ss_ready) begin
          @(posedge clk); #1;
          break;
        end
        @(posedge clk); #1;
        stalls++;
        if (stalls > 200) begin
          stuck    = 1'b1;
          ss_valid = 1'b0;
          return;
        end
      end
    end
    ss_valid = 1'b0;
    ss_last  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && ms_valid; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; ms_ready = 1'b0; ss_valid = 1'b0; ss_last = 1'b0; ss_data = '0;
    #2;
    checks++; if (ms_valid !== 1'b0) begin errors++; $display("FAIL reset_ms_valid got=%b exp=0", ms_valid); end
    checks++; if (ms_data !== 72'h0) begin errors++; $display("FAIL reset_ms_data got=%h exp=0", ms_data); end
    checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL reset_pkt_count got=%0d exp=0", pkt_count); end
    checks++; if (ss_ready !== 1'b0) begin errors++; $display("FAIL reset_ss_ready got=%b exp=0", ss_ready); end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    checks++; if (ss_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ss_ready got=%b exp=1", ss_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_pair();
    ms_ready = 1'b1;
    ss_data = 32'h11111111; ss_last = 1'b0; ss_valid = 1'b1;
    @(posedge clk); #1;
    ss_data = 32'h22222222; ss_last = 1'b1;
    @(posedge clk); #1;
    ss_valid = 1'b0; ss_last = 1'b0;
    checks++; if (ms_valid !== 1'b1) begin errors++; $display("FAIL pair_valid got=%b exp=1", ms_valid); end
    checks++;
    if (ms_data !== {6'd0, 1'b0, 1'b1, 32'h22222222, 32'h11111111}) begin
      errors++; $display("FAIL pair_data got=%h exp=%h", ms_data, {6'd0, 1'b0, 1'b1, 32'h22222222, 32'h11111111});
    end
    @(posedge clk); #1;
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL pair_pkt_count got=%0d exp=1", pkt_count); end
    checks++; if (ms_valid !== 1'b0) begin errors++; $display("FAIL pair_valid_clear got=%b exp=0", ms_valid); end
  endtask

  task automatic test_single();
    ms_ready = 1'b1;
    ss_data = 32'hAAAA5555; ss_last = 1'b1; ss_valid = 1'b1;
    #1;
    checks++; if (ss_ready !== 1'b1) begin errors++; $display("FAIL single_ss_ready got=%b exp=1", ss_ready); end
    @(posedge clk); #1;
    ss_valid = 1'b0; ss_last = 1'b0;
    checks++;
    if (ms_data !== {6'd0, 2'b11, 32'h0, 32'hAAAA5555} || ms_valid !== 1'b1) begin
      errors++; $display("FAIL single_data got=%h v=%b exp=%h v=1", ms_data, ms_valid, {6'd0, 2'b11, 32'h0, 32'hAAAA5555});
    end
    drain();
    got.delete(); stalls = 0; stuck = 1'b0;
    send_pkt(2, 32'hB0000000);
    drain();
    checks++;
    if (got.size() != 1 || got[0] !== {6'd0, 1'b0, 1'b1, 32'hB0000001, 32'hB0000000}) begin
      errors++; $display("FAIL single_next_seq got_n=%0d word0=%h exp=%h", got.size(),
                         (got.size() > 0) ? got[0] : 72'h0, {6'd0, 1'b0, 1'b1, 32'hB0000001, 32'hB0000000});
    end
    checks++; if (pkt_count !== 16'd3) begin errors++; $display("FAIL single_pkt_count got=%0d exp=3", pkt_count); end
  endtask

  task automatic test_six();
    logic [71:0] exp;
    int bad;
    ms_ready = 1'b1;
    got.delete(); stalls = 0; stuck = 1'b0;
    send_pkt(6, 32'hC0000000);
    drain();
    checks++; if (stuck || stalls != 0) begin errors++; $display("FAIL six_bubbles got=%0d exp=0", stalls); end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL six_words got=%0d exp=3", got.size()); end
    bad = 0;
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      exp = {6'(k), 1'b0, (k == 2), 32'hC0000000 + 32'(2*k+1), 32'hC0000000 + 32'(2*k)};
      if (got[k] !== exp) begin
        bad++; $display("FAIL six_word%0d got=%h exp=%h", k, got[k], exp);
      end
    end
    checks++; if (bad != 0) errors++;
    checks++; if (pkt_count !== 16'd4) begin errors++; $display("FAIL six_pkt_count got=%0d exp=4", pkt_count); end
  endtask

  task automatic test_backpressure();
    logic [71:0] w0, w1;
    int bad;
    w0 = {6'd0, 1'b0, 1'b0, 32'hD0000001, 32'hD0000000};
    w1 = {6'd1, 1'b0, 1'b1, 32'hD0000003, 32'hD0000002};
    got.delete();
    ms_ready = 1'b0;
    ss_data = 32'hD0000000; ss_last = 1'b0; ss_valid = 1'b1;
    @(posedge clk); #1;
    ss_data = 32'hD0000001;
    @(posedge clk); #1;
    ss_data = 32'hD0000002;
    #1;
    checks++; if (ss_ready !== 1'b1) begin errors++; $display("FAIL bp_low_beat_ready got=%b exp=1", ss_ready); end
    @(posedge clk); #1;
    ss_data = 32'hD0000003; ss_last = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (ss_ready !== 1'b0 || ms_data !== w0 || ms_valid !== 1'b1) begin
        bad++; $display("FAIL bp_stall cyc=%0d ss_ready=%b ms_data=%h exp_ready=0 exp_data=%h", c, ss_ready, ms_data, w0);
      end
      @(posedge clk); #1;
    end
    checks++; if (bad != 0) errors++;
    ms_ready = 1'b1;
    @(posedge clk); #1;
    ss_valid = 1'b0; ss_last = 1'b0;
    checks++;
    if (ms_valid !== 1'b1 || ms_data !== w1) begin
      errors++; $display("FAIL bp_overlap got=%h v=%b exp=%h v=1", ms_data, ms_valid, w1);
    end
    drain();
    checks++;
    if (got.size() != 2 || got[0] !== w0 || got[1] !== w1) begin
      errors++; $display("FAIL bp_words n=%0d exp=2 first=%h exp_first=%h", got.size(),
                         (got.size() > 0) ? got[0] : 72'h0, w0);
    end
    checks++; if (pkt_count !== 16'd5) begin errors++; $display("FAIL bp_pkt_count got=%0d exp=5", pkt_count); end
  endtask

  task automatic test_long();
    logic [71:0] exp;
    int bad;
    ms_ready = 1'b1;
    got.delete(); stalls = 0; stuck = 1'b0;
    send_pkt(130, 32'hE0000000);
    drain();
    checks++; if (stuck || got.size() != 65) begin errors++; $display("FAIL long_words got=%0d exp=65", got.size()); end
    bad = 0;
    for (int k = 0; k < 65 && k < got.size(); k++) begin
      exp = {6'(k % 64), 1'b0, (k == 64), 32'hE0000000 + 32'(2*k+1), 32'hE0000000 + 32'(2*k)};
      if (got[k] !== exp) begin
        bad++; $display("FAIL long_word%0d got=%h exp=%h", k, got[k], exp);
      end
    end
    checks++; if (bad != 0) errors++;
    checks++; if (pkt_count !== 16'd6) begin errors++; $display("FAIL long_pkt_count got=%0d exp=6", pkt_count); end
  endtask

  task automatic test_reset_mid();
    ms_ready = 1'b0;
    ss_data = 32'hF0000000; ss_last = 1'b0; ss_valid = 1'b1;
    @(posedge clk); #1;
    ss_data = 32'hF0000001;
    @(posedge clk); #1;
    ss_data = 32'hF0000002;
    @(posedge clk); #1;
    ss_valid = 1'b0;
    #1 resetn = 1'b0;
    #1;
    checks++; if (ms_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got=%b exp=0", ms_valid); end
    checks++; if (ss_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got=%b exp=0", ss_ready); end
    checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL mid_reset_cnt got=%0d exp=0", pkt_count); end
    @(posedge clk); #1;
    resetn = 1'b1; ms_ready = 1'b1;
    @(posedge clk); #1;
    got.delete(); stalls = 0; stuck = 1'b0;
    send_pkt(2, 32'h0BAD0000);
    drain();
    checks++;
    if (got.size() != 1 || got[0] !== {6'd0, 1'b0, 1'b1, 32'h0BAD0001, 32'h0BAD0000}) begin
      errors++; $display("FAIL mid_reset_fresh n=%0d word0=%h exp=%h", got.size(),
                         (got.size() > 0) ? got[0] : 72'h0, {6'd0, 1'b0, 1'b1, 32'h0BAD0001, 32'h0BAD0000});
    end
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL mid_reset_pkt got=%0d exp=1", pkt_count); end
  endtask

  initial begin
    stalls = 0;
    stuck  = 1'b0;
    test_reset();
    test_pair();
    test_single();
    test_six();
    test_backpressure();
    test_long();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
